// File: rtl/cv32e40p_pkg.sv
// Shared types for the EX->WB stage.
//   ex_wb_entry_t : payload carried from EX to the register-file write port
//   EXWB_DEPTH    : number of buffered writeback entries (main + skid)
package cv32e40p_pkg;

  localparam int unsigned EXWB_DATA_W  = 32;
  localparam int unsigned EXWB_RADDR_W = 5;
  localparam int unsigned EXWB_DEPTH   = 2;

  typedef struct packed {
    logic [EXWB_RADDR_W-1:0] rd_addr;
    logic [EXWB_DATA_W-1:0]  data;
  } ex_wb_entry_t;

endpackage

// File: rtl/cv32e40p_skid_buf.sv
// Two-entry valid/ready skid buffer with synchronous flush.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   flush                drop both entries and any incoming entry at the next edge
//   in_valid/in_ready    upstream handshake; in_ready = ~skid_valid (no combinational path
//                        from out_ready)
//   in_data              upstream payload
//   out_valid/out_ready  downstream handshake, head of the buffer
//   out_data             head payload, held stable while out_valid & ~out_ready
module cv32e40p_skid_buf #(
  parameter type entry_t = logic [7:0]
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   in_valid,
  output logic   in_ready,
  input  entry_t in_data,
  output logic   out_valid,
  input  logic   out_ready,
  output entry_t out_data
);

  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   enq, deq;

  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_q;
  assign enq       = in_valid & in_ready;
  assign deq       = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      unique case ({main_valid_q, skid_valid_q})
        2'b00: begin
          if (enq) begin
            main_valid_d = 1'b1;
            main_d       = in_data;
          end
        end
        2'b10: begin
          if (enq && deq) begin
            main_d = in_data;
          end else if (enq) begin
            // Head is stalled: park the newcomer behind it.
            skid_valid_d = 1'b1;
            skid_d       = in_data;
          end else if (deq) begin
            main_valid_d = 1'b0;
          end
        end
        2'b11: begin
          if (deq) begin
            main_d       = skid_q;
            skid_valid_d = 1'b0;
          end
        end
        default: begin
          // Skid without main is unreachable; recover to empty.
          main_valid_d = 1'b0;
          skid_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

endmodule

// File: rtl/cv32e40p_ex_wb_stage.sv
// EX->WB stage: captures ALU results, resolves conditional branches from the ALU comparison
// bit and forwards register-writing results to WB through a 2-entry skid buffer.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   ex_valid_i / ex_ready_o      EX handshake (ex_ready_o = ~skid occupied)
//   ex_is_branch_i, ex_branch_tgt_i, ex_rd_addr_i, ex_rd_we_i   instruction attributes
//   alu_result_i, alu_cmp_i      ALU outputs
//   flush_i                      drop buffered/incoming entries and any redirect
//   wb_valid_o / wb_ready_i      WB handshake; wb_rd_addr_o, wb_data_o head entry
//   branch_taken_o, branch_tgt_o registered one-cycle redirect and its target
module cv32e40p_ex_wb_stage
  import cv32e40p_pkg::*;
#(
  parameter int unsigned DATA_W  = EXWB_DATA_W,
  parameter int unsigned RADDR_W = EXWB_RADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_valid_i,
  output logic               ex_ready_o,
  input  logic               ex_is_branch_i,
  input  logic [DATA_W-1:0]  ex_branch_tgt_i,
  input  logic [RADDR_W-1:0] ex_rd_addr_i,
  input  logic               ex_rd_we_i,
  input  logic [DATA_W-1:0]  alu_result_i,
  input  logic               alu_cmp_i,
  input  logic               flush_i,
  output logic               wb_valid_o,
  input  logic               wb_ready_i,
  output logic [RADDR_W-1:0] wb_rd_addr_o,
  output logic [DATA_W-1:0]  wb_data_o,
  output logic               branch_taken_o,
  output logic [DATA_W-1:0]  branch_tgt_o
);

  logic               kill_shadow_q;
  logic               branch_taken_q;
  logic [DATA_W-1:0]  branch_tgt_q;
  logic               accept, taken, enq_valid, buf_in_ready;
  ex_wb_entry_t       enq_entry, head_entry;

  // kill_shadow still lets EX hand over (ready stays high) but the transfer is discarded.
  assign accept    = ex_valid_i & ex_ready_o & ~flush_i & ~kill_shadow_q;
  assign taken     = accept & ex_is_branch_i & alu_cmp_i;
  assign enq_valid = accept & ~ex_is_branch_i & ex_rd_we_i & (ex_rd_addr_i != '0);

  assign enq_entry.rd_addr = ex_rd_addr_i;
  assign enq_entry.data    = alu_result_i;

  cv32e40p_skid_buf #(
    .entry_t (ex_wb_entry_t)
  ) u_skid_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush_i),
    .in_valid  (enq_valid),
    .in_ready  (buf_in_ready),
    .in_data   (enq_entry),
    .out_valid (wb_valid_o),
    .out_ready (wb_ready_i),
    .out_data  (head_entry)
  );

  assign ex_ready_o   = buf_in_ready;
  assign wb_rd_addr_o = head_entry.rd_addr;
  assign wb_data_o    = head_entry.data;

  // flush_i already gates accept, so it also suppresses the redirect and shadow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_taken_q <= 1'b0;
      branch_tgt_q   <= '0;
      kill_shadow_q  <= 1'b0;
    end else begin
      branch_taken_q <= taken;
      kill_shadow_q  <= taken;
      if (taken) begin
        branch_tgt_q <= ex_branch_tgt_i;
      end
    end
  end

  assign branch_taken_o = branch_taken_q;
  assign branch_tgt_o   = branch_tgt_q;

endmodule

// File: tb/tb_cv32e40p_ex_wb_stage.sv
module tb_cv32e40p_ex_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i, ex_ready_o, ex_is_branch_i, ex_rd_we_i, alu_cmp_i, flush_i;
  logic [31:0] ex_branch_tgt_i, alu_result_i, wb_data_o, branch_tgt_o;
  logic [4:0]  ex_rd_addr_i, wb_rd_addr_o;
  logic        wb_valid_o, wb_ready_i, branch_taken_o;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;  // expected handshake cycle, -1 = don't care
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  cv32e40p_ex_wb_stage dut (
    .clk             (clk),
    .rst             (rst),
    .ex_valid_i      (ex_valid_i),
    .ex_ready_o      (ex_ready_o),
    .ex_is_branch_i  (ex_is_branch_i),
    .ex_branch_tgt_i (ex_branch_tgt_i),
    .ex_rd_addr_i    (ex_rd_addr_i),
    .ex_rd_we_i      (ex_rd_we_i),
    .alu_result_i    (alu_result_i),
    .alu_cmp_i       (alu_cmp_i),
    .flush_i         (flush_i),
    .wb_valid_o      (wb_valid_o),
    .wb_ready_i      (wb_ready_i),
    .wb_rd_addr_o    (wb_rd_addr_o),
    .wb_data_o       (wb_data_o),
    .branch_taken_o  (branch_taken_o),
    .branch_tgt_o    (branch_tgt_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard monitor: a WB transfer happens at the next rising edge when valid & ready.
  always @(negedge clk) begin
    if (!rst && wb_valid_o && wb_ready_i) begin
      if (sb.size() == 0) begin
        check("wb_unexpected", 64'(wb_rd_addr_o), 64'hFFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wb_rd", 64'(wb_rd_addr_o), 64'(e.rd));
        check("wb_data", 64'(wb_data_o), 64'(e.data));
        if (e.cyc >= 0) check("wb_latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid_i = 1'b0;
    ex_is_branch_i = 1'b0;
    alu_cmp_i = 1'b0;
    ex_rd_we_i = 1'b0;
  endtask

  task automatic alu_op(input logic [4:0] rd, input logic we, input logic [31:0] d);
    ex_valid_i = 1'b1;
    ex_is_branch_i = 1'b0;
    alu_cmp_i = 1'b0;
    ex_rd_addr_i = rd;
    ex_rd_we_i = we;
    alu_result_i = d;
  endtask

  task automatic br_op(input logic cmp, input logic [31:0] tgt);
    ex_valid_i = 1'b1;
    ex_is_branch_i = 1'b1;
    alu_cmp_i = cmp;
    ex_branch_tgt_i = tgt;
    ex_rd_we_i = 1'b0;
    ex_rd_addr_i = 5'd0;
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] d, input int c);
    exp_t e;
    e.rd = rd;
    e.data = d;
    e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic fill_full(input logic [4:0] base);
    wb_ready_i = 1'b0;
    alu_op(base, 1'b1, 32'h100 + 32'(base));
    push(base, 32'h100 + 32'(base), -1);
    tick();
    alu_op(base + 5'd1, 1'b1, 32'h101 + 32'(base));
    push(base + 5'd1, 32'h101 + 32'(base), -1);
    tick();
    idle();
    check("full_ex_ready", 64'(ex_ready_o), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    flush_i = 1'b0;
    wb_ready_i = 1'b1;
    ex_branch_tgt_i = '0;
    alu_result_i = '0;
    ex_rd_addr_i = '0;
    idle();
    repeat (3) tick();
    check("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    check("rst_branch_taken", 64'(branch_taken_o), 64'd0);
    check("rst_branch_tgt", 64'(branch_tgt_o), 64'd0);
    rst = 1'b0;
    tick();
    check("rst_ex_ready", 64'(ex_ready_o), 64'd1);

    // Back-to-back writes, one-cycle latency, one per cycle.
    wb_ready_i = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      alu_op(5'(i), 1'b1, 32'(i * 16));
      push(5'(i), 32'(i * 16), cyc + 1);
      tick();
    end
    idle();
    repeat (3) tick();
    check("b2b_sb_empty", 64'(sb.size()), 64'd0);

    // Backpressure: two entries fill main + skid, head held stable.
    wb_ready_i = 1'b0;
    alu_op(5'd5, 1'b1, 32'hA);
    push(5'd5, 32'hA, -1);
    tick();
    check("one_ex_ready", 64'(ex_ready_o), 64'd1);
    alu_op(5'd6, 1'b1, 32'hB);
    push(5'd6, 32'hB, -1);
    tick();
    idle();
    check("bp_ex_ready", 64'(ex_ready_o), 64'd0);
    repeat (2) tick();
    check("bp_hold_rd", 64'(wb_rd_addr_o), 64'd5);
    check("bp_hold_data", 64'(wb_data_o), 64'hA);
    check("bp_hold_valid", 64'(wb_valid_o), 64'd1);
    wb_ready_i = 1'b1;
    repeat (3) tick();
    check("bp_sb_empty", 64'(sb.size()), 64'd0);
    check("bp_drained_ready", 64'(ex_ready_o), 64'd1);

    // Taken branch: one-cycle redirect, shadow instruction discarded.
    br_op(1'b1, 32'h8000_0040);
    tick();
    check("br_taken", 64'(branch_taken_o), 64'd1);
    check("br_tgt", 64'(branch_tgt_o), 64'h8000_0040);
    alu_op(5'd7, 1'b1, 32'h77);
    check("shadow_ex_ready", 64'(ex_ready_o), 64'd1);
    tick();
    check("br_pulse_end", 64'(branch_taken_o), 64'd0);
    idle();
    repeat (2) tick();
    check("shadow_wb_valid", 64'(wb_valid_o), 64'd0);
    // Not-taken branch: no pulse, target held, following write goes through.
    br_op(1'b0, 32'h1234_5678);
    tick();
    check("nt_taken", 64'(branch_taken_o), 64'd0);
    check("nt_tgt_held", 64'(branch_tgt_o), 64'h8000_0040);
    alu_op(5'd7, 1'b1, 32'h77);
    push(5'd7, 32'h77, cyc + 1);
    tick();
    idle();
    repeat (2) tick();
    check("nt_sb_empty", 64'(sb.size()), 64'd0);

    // rd=0 and rd_we=0 are accepted but produce no WB traffic.
    alu_op(5'd0, 1'b1, 32'hDEAD);
    tick();
    check("rd0_ex_ready", 64'(ex_ready_o), 64'd1);
    alu_op(5'd3, 1'b0, 32'hBEEF);
    tick();
    check("we0_ex_ready", 64'(ex_ready_o), 64'd1);
    idle();
    tick();
    check("drop_wb_valid", 64'(wb_valid_o), 64'd0);

    // Flush with a full buffer and a simultaneous taken branch.
    fill_full(5'd10);
    flush_i = 1'b1;
    br_op(1'b1, 32'hCAFE_0000);
    tick();
    flush_i = 1'b0;
    idle();
    sb.delete();
    check("flush_wb_valid", 64'(wb_valid_o), 64'd0);
    check("flush_ex_ready", 64'(ex_ready_o), 64'd1);
    check("flush_no_redirect", 64'(branch_taken_o), 64'd0);
    check("flush_tgt_held", 64'(branch_tgt_o), 64'h8000_0040);
    wb_ready_i = 1'b1;
    alu_op(5'd12, 1'b1, 32'h55);
    push(5'd12, 32'h55, cyc + 1);
    tick();
    idle();
    repeat (2) tick();
    check("flush_sb_empty", 64'(sb.size()), 64'd0);

    // Reset mid-stream with a full buffer.
    fill_full(5'd20);
    rst = 1'b1;
    #1;
    sb.delete();
    check("midrst_wb_valid", 64'(wb_valid_o), 64'd0);
    check("midrst_ex_ready", 64'(ex_ready_o), 64'd1);
    tick();
    rst = 1'b0;
    tick();
    // Reset right after a taken branch kills the pending redirect.
    wb_ready_i = 1'b1;
    br_op(1'b1, 32'h0000_0F00);
    tick();
    idle();
    rst = 1'b1;
    #1;
    check("midrst_branch_taken", 64'(branch_taken_o), 64'd0);
    check("midrst_branch_tgt", 64'(branch_tgt_o), 64'd0);
    tick();
    rst = 1'b0;
    repeat (2) tick();
    check("post_rst_wb_valid", 64'(wb_valid_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
